// File: rtl/apu_pkg.sv
// apu_pkg: shared types and limits for the APU channel-1 sweep unit.
package apu_pkg;
  typedef logic [10:0] freq_t;
  typedef enum logic [1:0] {IDLE, LOADED, SHIFTING, SUMMED} sweep_state_t;
  localparam int SWEEP_MAX_SHIFT = 7;
endpackage

// File: rtl/ch1_sweep_shifter.sv
// ch1_sweep_shifter: shadow copy of the period, shifted right up to SWEEP_MAX_SHIFT times.
module ch1_sweep_shifter
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  freq_t      din,
  output freq_t      dout,
  output logic [2:0] count
);
  freq_t shadow_q;
  logic [2:0] count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else if (load) begin
      shadow_q <= din;
      count_q  <= '0;
    end else if (shift && count_q != 3'(SWEEP_MAX_SHIFT)) begin
      shadow_q <= shadow_q >> 1;
      count_q  <= count_q + 3'd1;
    end
  assign dout  = shadow_q;
  assign count = count_q;
endmodule

// File: rtl/ch1_sweep.sv
// ch1_sweep: channel-1 frequency sweep (load/shift/sum/commit) with CPU period writes.
// Overflow detection is built only when CH1_SWEEP_OVF_EN is defined; otherwise add results wrap.
module ch1_sweep
  import apu_pkg::*;
(
  input  logic        ajer_2mhz,
  input  logic        apu_reset,
  input  logic [7:0]  d,
  input  logic        apu_wr,
  input  logic        ff13,
  input  logic        ff14,
  input  logic        ff10_d3,
  input  logic        ch1_restart,
  input  logic        ch1_ld_shift,
  input  logic        ch1_shift_clk,
  input  logic        ch1_freq_upd1,
  input  logic        ch1_freq_upd2,
  output logic [10:0] ch1_freq,
  output logic        ch1_sweep_ovf,
  output logic        ch1_sweep_busy
);
  sweep_state_t state_q, state_d;
  freq_t freq_q, freq_d, sum_q, sum_d, shadow, base;
  logic [2:0] shift_cnt;
  logic ovf_q, ovf_d, active, ld, upd1, shift, upd2, commit;
  assign active = state_q == LOADED || state_q == SHIFTING;
  assign ld     = ch1_ld_shift && !ch1_restart;
  assign upd1   = ch1_freq_upd1 && active && !ld && !ch1_restart;
  assign shift  = ch1_shift_clk && active && !ld && !upd1 && !ch1_restart;
  assign upd2   = ch1_freq_upd2 && state_q == SUMMED && !ld && !ch1_restart;
  assign commit = upd2 && !ovf_q;
`ifdef CH1_SWEEP_OVF_EN
  // Bit 11 is only meaningful as an add carry; subtract wraps mod 4096.
  logic [11:0] raw;
  assign raw   = ff10_d3 ? {1'b0, freq_q} - {1'b0, shadow} : {1'b0, freq_q} + {1'b0, shadow};
  assign ovf_d = !ch1_restart && (ovf_q || (upd1 && !ff10_d3 && raw[11]));
`else
  freq_t raw;
  assign raw   = ff10_d3 ? freq_q - shadow : freq_q + shadow;
  assign ovf_d = 1'b0;
`endif
  ch1_sweep_shifter u_shifter (
    .clk  (ajer_2mhz),
    .rst  (apu_reset),
    .load (ld),
    .shift(shift),
    .din  (freq_q),
    .dout (shadow),
    .count(shift_cnt)
  );
  // CPU writes override the commit only on the bits they touch.
  always_comb begin
    base    = commit ? sum_q : freq_q;
    freq_d  = {(apu_wr && ff14) ? d[2:0] : base[10:8], (apu_wr && ff13) ? d : base[7:0]};
    sum_d   = upd1 ? raw[10:0] : sum_q;
    state_d = ch1_restart ? IDLE : ld ? LOADED : upd1 ? SUMMED : shift ? SHIFTING : upd2 ? IDLE : state_q;
  end
  always_ff @(posedge ajer_2mhz or posedge apu_reset)
    if (apu_reset) begin
      state_q <= IDLE;
      freq_q  <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  assign ch1_freq       = freq_q;
  assign ch1_sweep_ovf  = ovf_q;
  assign ch1_sweep_busy = state_q != IDLE;
endmodule

// File: tb/tb_ch1_sweep.sv
// tb_ch1_sweep: directed and randomized checks of ch1_sweep against a behavioural model.
module tb_ch1_sweep;
  logic clk = 1'b0, apu_reset = 1'b0;
  logic [7:0] d = '0;
  logic apu_wr = 0, ff13 = 0, ff14 = 0, ff10_d3 = 0, ch1_restart = 0;
  logic ch1_ld_shift = 0, ch1_shift_clk = 0, ch1_freq_upd1 = 0, ch1_freq_upd2 = 0;
  logic [10:0] ch1_freq;
  logic ch1_sweep_ovf, ch1_sweep_busy;
  int n_chk = 0, n_fail = 0;
  int m_freq, m_shadow, m_cnt, m_sum, m_st;
  bit m_ovf;
  bit ovf_en;
  ch1_sweep dut (
    .ajer_2mhz(clk), .apu_reset(apu_reset), .d(d), .apu_wr(apu_wr), .ff13(ff13), .ff14(ff14),
    .ff10_d3(ff10_d3), .ch1_restart(ch1_restart), .ch1_ld_shift(ch1_ld_shift),
    .ch1_shift_clk(ch1_shift_clk), .ch1_freq_upd1(ch1_freq_upd1), .ch1_freq_upd2(ch1_freq_upd2),
    .ch1_freq(ch1_freq), .ch1_sweep_ovf(ch1_sweep_ovf), .ch1_sweep_busy(ch1_sweep_busy)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_freq = 0; m_shadow = 0; m_cnt = 0; m_sum = 0; m_st = 0; m_ovf = 0;
  endtask
  task automatic cyc(input int dv, input bit w13, w14, rs, ld, sh, u1, u2, dir);
    int nf, r;
    @(negedge clk);
    d = 8'(dv); apu_wr = w13 | w14; ff13 = w13; ff14 = w14; ff10_d3 = dir;
    ch1_restart = rs; ch1_ld_shift = ld; ch1_shift_clk = sh; ch1_freq_upd1 = u1; ch1_freq_upd2 = u2;
    @(posedge clk);
    #1;
    apu_wr = 0; ff13 = 0; ff14 = 0; ch1_restart = 0;
    ch1_ld_shift = 0; ch1_shift_clk = 0; ch1_freq_upd1 = 0; ch1_freq_upd2 = 0;
    nf = m_freq;
    if (rs) begin
      m_ovf = 0; m_st = 0;
    end else if (ld) begin
      m_shadow = m_freq; m_cnt = 0; m_st = 1;
    end else if (u1 && (m_st == 1 || m_st == 2)) begin
      r = dir ? (m_freq - m_shadow) & 4095 : m_freq + m_shadow;
      m_sum = r % 2048;
      if (ovf_en && !dir && r > 2047) m_ovf = 1;
      m_st = 3;
    end else if (sh && (m_st == 1 || m_st == 2)) begin
      if (m_cnt < 7) begin m_shadow = m_shadow / 2; m_cnt++; end
      m_st = 2;
    end else if (u2 && m_st == 3) begin
      if (!m_ovf) nf = m_sum;
      m_st = 0;
    end
    if (w13) nf = (nf & 'h700) | (dv & 'hFF);
    if (w14) nf = (nf & 'hFF) | ((dv & 7) << 8);
    m_freq = nf;
    chk("model_freq", ch1_freq, m_freq);
    chk("model_ovf", ch1_sweep_ovf, m_ovf);
    chk("model_busy", ch1_sweep_busy, m_st != 0);
  endtask
  task automatic idle();           cyc(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr_freq(input int f);
    cyc(f & 'hFF, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(f >> 8, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic async_reset();
    @(posedge clk);
    #2 apu_reset = 1;
    #1;
    chk("rst_freq", ch1_freq, 0);
    chk("rst_ovf", ch1_sweep_ovf, 0);
    chk("rst_busy", ch1_sweep_busy, 0);
    m_reset();
    @(negedge clk);
    apu_reset = 0;
  endtask
  initial begin
`ifdef CH1_SWEEP_OVF_EN
    ovf_en = 1;
`else
    ovf_en = 0;
`endif
    m_reset();
    async_reset();
    // basic add with one shift
    wr_freq('h400);
    chk("wr_freq", ch1_freq, 'h400);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("busy_loaded", ch1_sweep_busy, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("add_freq", ch1_freq, 'h600);
    chk("add_ovf", ch1_sweep_ovf, 0);
    chk("add_idle", ch1_sweep_busy, 0);
    // overflowing add
    wr_freq('h700);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("ovf_set", ch1_sweep_ovf, ovf_en ? 1 : 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("ovf_hold", ch1_freq, ovf_en ? 'h700 : 'h280);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("restart_clr", ch1_sweep_ovf, 0);
    // subtract with two shifts
    wr_freq('h100);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("sub_freq", ch1_freq, 'h0C0);
    // shift saturation
    wr_freq('h7FF);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("sat_count", dut.shift_cnt, 7);
    chk("sat_shadow", dut.shadow, 'h00F);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("sat_sub", ch1_freq, 'h7F0);
    // CPU write colliding with a commit of 0x123
    wr_freq('h121);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc('h55, 1, 0, 0, 0, 0, 0, 1, 0);
    chk("wr_vs_commit", ch1_freq, 'h155);
    chk("wr_commit_idle", ch1_sweep_busy, 0);
    // reset while a sum is pending
    wr_freq('h400);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("summed_busy", ch1_sweep_busy, 1);
    async_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_discard", ch1_freq, 0);
    // randomized single-strobe traffic
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 11);
      int dv = $urandom_range(0, 255);
      bit dir = 1'($urandom_range(0, 1));
      case (r)
        0:       cyc(dv, 0, 0, 1, 0, 0, 0, 0, dir);
        1, 2:    cyc(dv, 0, 0, 0, 1, 0, 0, 0, dir);
        3, 4, 5: cyc(dv, 0, 0, 0, 0, 1, 0, 0, dir);
        6:       cyc(dv, 0, 0, 0, 0, 0, 1, 0, dir);
        7:       cyc(dv, $urandom_range(0, 3) == 0, 0, 0, 0, 0, 0, 1, dir);
        8:       cyc(dv, 1, 0, 0, 0, 0, 0, 0, dir);
        9:       cyc(dv, 0, 1, 0, 0, 0, 0, 0, dir);
        default: idle();
      endcase
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ch1_sweep.md
CH1_SWEEP -- requirements
Module: ch1_sweep

Interface
REQ-001 SHALL have exactly one clock and asynchronous, active-high reset: `ajer_2mhz` clock, `apu_reset` reset.
REQ-002 `ajer_2mhz`  in  1   sole clock; all state updates on rising edge.
REQ-003 `apu_reset`  in  1   asynchronous active-high reset.
REQ-004 `d`  in  8   CPU data bus.
REQ-005 `apu_wr`  in  1   CPU write strobe, one cycle.
REQ-006 `ff13`, `ff14`  in  1 each   register selects; write = `apu_wr` && select.
REQ-007 `ff10_d3`  in  1   sweep direction; 1 = subtract.
REQ-008 `ch1_restart`  in  1   channel trigger pulse.
REQ-009 `ch1_ld_shift`, `ch1_shift_clk`, `ch1_freq_upd1`, `ch1_freq_upd2`  in  1 each   single-cycle sweep strobes from channel 1.
REQ-010 `ch1_freq`  out  11   current period value, fed to the frequency counter.
REQ-011 `ch1_sweep_ovf`  out  1   overflow; channel 1 uses it to disable itself.
REQ-012 `ch1_sweep_busy`  out  1   high in any state other than IDLE.

Function
REQ-013 `ff13` write SHALL load `ch1_freq[7:0]` from `d`; `ff14` write SHALL load `ch1_freq[10:8]` from `d[2:0]`.
REQ-014 FSM states SHALL be IDLE, LOADED, SHIFTING, SUMMED.
REQ-015 `ch1_ld_shift` in any state SHALL copy `ch1_freq` into an 11-bit shadow, clear the shift count, and enter LOADED.
REQ-016 `ch1_shift_clk` in LOADED or SHIFTING SHALL shift the shadow right by 1 (zero fill), increment the count, and enter SHIFTING.
REQ-016a Once the count reaches 7, further `ch1_shift_clk` SHALL be ignored: shadow and count hold.
REQ-016b `ch1_shift_clk` in IDLE or SUMMED SHALL be ignored.
REQ-017 `ch1_freq_upd1` in LOADED or SHIFTING SHALL latch a 12-bit sum and enter SUMMED.
REQ-017a Sum = `ch1_freq` + shadow, or `ch1_freq` − shadow when `ff10_d3` = 1.
REQ-017b Subtraction SHALL be computed modulo 4096; bit 11 of a subtract result SHALL be ignored.
REQ-018 An add sum > 2047 SHALL set `ch1_sweep_ovf` on the following edge.
REQ-019 `ch1_freq_upd2` in SUMMED SHALL write sum[10:0] into `ch1_freq` when `ch1_sweep_ovf` = 0, then return to IDLE.
REQ-019a When `ch1_sweep_ovf` = 1, `ch1_freq_upd2` SHALL leave `ch1_freq` unchanged and return to IDLE.
REQ-020 When a CPU write and an `ch1_freq_upd2` commit occur in the same cycle, the CPU write SHALL win on the written bits, and the FSM SHALL still return to IDLE.
REQ-021 `ch1_restart` SHALL clear `ch1_sweep_ovf` and force IDLE.
REQ-021a `ch1_restart` has priority over every same-cycle strobe except a CPU write to `ch1_freq`.
REQ-022 Every output SHALL be registered, with 1-cycle latency from the causing strobe.

Reset
REQ-023 While `apu_reset` = 1 (asynchronous assertion): `ch1_freq` = 0, shadow = 0, count = 0, sum = 0, `ch1_sweep_ovf` = 0, `ch1_sweep_busy` = 0, state = IDLE.
REQ-024 Reset asserted mid-operation SHALL discard any pending sum without committing it.

Configuration
REQ-025 Macro `CH1_SWEEP_OVF_EN`.
REQ-025a When `CH1_SWEEP_OVF_EN` is defined, overflow detection SHALL behave per REQ-018/019a.
REQ-025b When `CH1_SWEEP_OVF_EN` is undefined, `ch1_sweep_ovf` SHALL be tied to 0 and add results SHALL wrap modulo 2048 on commit.

Structure
REQ-026 Shared package `apu_pkg` SHALL hold:
- `freq_t` (11-bit logic);
- the `sweep_state_t` enum;
- `SWEEP_MAX_SHIFT` = 7.
REQ-027 The shadow shifter and its count SHALL be a sub-module `ch1_sweep_shifter`, with ports: load, shift, din, dout, count.

Verification
REQ-028 Write `ff13` = 0x00, `ff14` d[2:0] = 0b100 (`ch1_freq` = 0x400), `ff10_d3` = 0; ld_shift, 1 shift_clk, upd1, upd2 -> `ch1_freq` = 0x600, ovf = 0.
REQ-029 `ch1_freq` = 0x700, add, ld_shift, 1 shift, upd1 -> ovf = 1 one cycle later; upd2 -> `ch1_freq` stays 0x700.
REQ-030 `ch1_freq` = 0x100, `ff10_d3` = 1, ld_shift, 2 shifts, upd1, upd2 -> `ch1_freq` = 0x0C0.
REQ-031 `ch1_freq` = 0x7FF, ld_shift, 10 shift_clk -> count saturates at 7, shadow = 0x00F.
REQ-032 `ff13` write of 0x55 in the same cycle as upd2 committing 0x123 -> `ch1_freq` = 0x155.
REQ-033 Assert `apu_reset` while in SUMMED -> all outputs 0 immediately; ovf set, then `ch1_restart` -> ovf = 0.
